alu_flag_stage: RTL
===================

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; MUL iteration count equals WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-006 a, b  input  WIDTH  operands; captured on start acceptance, ignored afterwards.
REQ-007 busy  output  1  high while an operation is in progress (EXEC or MUL state).
REQ-008 done  output  1  one-cycle pulse; result and flags valid in the same cycle.
REQ-009 result  output  WIDTH  registered result; holds until the next completion.
REQ-010 flags  output  4  registered {C,Z,S,V} (bit3 C, bit2 Z, bit1 S, bit0 V); drives the flag register input.
REQ-011 flag_we  output  1  equals done; write strobe for the downstream flag register.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC, MUL, DONE.
REQ-013 IDLE: start=1 with op!=MUL captures a, b, op and goes to EXEC; start=1 with op=MUL goes to MUL with iteration count 0; start=0 stays in IDLE.
REQ-014 EXEC SHALL compute the result and flags in one cycle, register them, and go to DONE.
REQ-015 MUL SHALL perform one shift-add step per cycle for WIDTH cycles, then go to DONE.
REQ-016 DONE SHALL assert done and flag_we for exactly one cycle, then return to IDLE.
REQ-017 Latency from the start-accept edge to done high: 2 cycles for non-MUL ops, WIDTH+1 cycles for MUL.
REQ-018 start outside IDLE SHALL be ignored, with no queuing; start in the same cycle that DONE is asserted SHALL also be ignored.
REQ-019 ADD: C = carry out of bit WIDTH-1; V = signed overflow (operands share a sign that differs from the result's sign).
REQ-020 SUB: result = a-b mod 2^WIDTH; C = borrow (1 iff a<b unsigned); V = signed overflow of a-b.
REQ-021 AND/OR/XOR: C=0, V=0.
REQ-022 SHL/SHR: logical shift by b[3:0]; C = last bit shifted out; amount 0 gives result=a and C=0; V=0.
REQ-023 MUL: unsigned; result = low WIDTH bits of the product; C=1 iff the high WIDTH bits are nonzero; V=0.
REQ-024 For all ops: Z=1 iff result==0; S=result[WIDTH-1].
REQ-025 result and flags SHALL change only on the edge entering DONE and remain stable otherwise.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, flag_we 0, result 0, flags 4'b0000, iteration counter and operand registers 0.
REQ-027 Reset during EXEC or MUL SHALL abort the operation; no done pulse follows after release.
REQ-028 The first start is accepted on the first rising edge with rst_n high.

Structure
REQ-029 A shared package SHALL hold the opcode constants, the flag bit indices (C=3, Z=2, S=1, V=0) and the FSM state encoding.
REQ-030 The iterative multiplier SHALL be the sub-module alu_mul_seq, with a start/done handshake and WIDTH-cycle latency; everything else stays in alu_flag_stage.

Verification
REQ-031 ADD a=16'h7FFF, b=16'h0001 -> result 16'h8000, flags {C0,Z0,S1,V1}, done exactly 2 cycles after the accept edge.
REQ-032 SUB a=16'h0003, b=16'h0005 -> result 16'hFFFE, flags {C1,Z0,S1,V0}; SUB a=b=16'h1234 -> result 0, Z=1.
REQ-033 SHL a=16'h8001, b=1 -> result 16'h0002, C=1; SHR with b=0 -> result=a, C=0.
REQ-034 MUL a=16'h0100, b=16'h0100 -> result 16'h0000, C=1, Z=1, done 17 cycles after accept; a second start pulsed while busy is ignored.
REQ-035 rst_n pulsed low at MUL iteration 8 -> outputs zero immediately, no done; a new ADD 2+3 then returns 5 with flags 4'b0000.

Source files
------------

// File: rtl/alu_flag_stage_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU flag stage.
package alu_flag_stage_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_flag_stage_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // done/product reflect the final step combinationally so the caller
  // can register the product on the same edge that retires it.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = run_q && (cnt_q == CW'(WIDTH - 1));
    product  = acc_step;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Multi-cycle ALU with {C,Z,S,V} flag generation and a one-cycle flag-register write strobe.
module alu_flag_stage
  import alu_flag_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             flag_we
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_c, exec_v;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    mk_flags         = '0;
    mk_flags[FLAG_C] = c;
    mk_flags[FLAG_Z] = (r == '0);
    mk_flags[FLAG_S] = r[WIDTH-1];
    mk_flags[FLAG_V] = v;
  endfunction

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Shifts are widened by one bit so the last bit shifted out lands in a
  // fixed position; a zero shift naturally yields C=0.
  always_comb begin
    sh       = b_q[SHW-1:0];
    add_w    = {1'b0, a_q} + {1'b0, b_q};
    sub_w    = {1'b0, a_q} - {1'b0, b_q};
    shl_w    = {1'b0, a_q} << sh;
    shr_w    = {a_q, 1'b0} >> sh;
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = add_w[WIDTH-1:0];
        exec_c   = add_w[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = sub_w[WIDTH-1:0];
        exec_c   = sub_w[WIDTH];
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SHL: begin
        exec_res = shl_w[WIDTH-1:0];
        exec_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        exec_res = shr_w[WIDTH:1];
        exec_c   = shr_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        op_d = op_e'(op);
        a_d  = a;
        b_d  = b;
        if (op_e'(op) == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = exec_res;
        flags_d  = mk_flags(exec_res, exec_c, 1'b0) | {3'b000, exec_v};
        state_d  = ST_DONE;
      end
      ST_MUL: if (mul_done) begin
        result_d = mul_prod[WIDTH-1:0];
        flags_d  = mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy    = (state_q == ST_EXEC) || (state_q == ST_MUL);
  assign done    = (state_q == ST_DONE);
  assign flag_we = done;
  assign result  = result_q;
  assign flags   = flags_q;

endmodule
